fifo_wr_sched: RTL

//  Write-side scheduler for the dual-clock FIFO. Round-robin arbitration lets NREQ

---
 rtl/fifo_defs.sv | 27 ++
 rtl/fifo_rr_arbiter.sv | 27 ++
 rtl/fifo_wr_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_defs.sv
// Shared definitions for the dual-clock FIFO: pointer code conversions,
// write-scheduler FSM encoding and default geometry.
package fifo_defs;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DSIZE_DEF    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Fixed 16-bit working width; callers zero-extend in and truncate out.
    function automatic logic [15:0] bin2gray(input logic [15:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [15:0] gray2bin(input logic [15:0] gray);
        logic [15:0] bin;
        bin[15] = gray[15];
        for (int i = 14; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Rotating-priority picker: grants the first unmasked requester at or after
// rr_ptr, one-hot, purely combinational.
module fifo_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] gnt
);

    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   req_rot;
    logic [NREQ-1:0]   pick_rot;
    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] pick_dbl;

    assign req_eff  = req & ~mask;
    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
    assign req_dbl  = {req_eff, req_eff};
    assign req_rot  = NREQ'(req_dbl >> rr_ptr);
    assign pick_rot = req_rot & (~req_rot + NREQ'(1));
    assign pick_dbl = {pick_rot, pick_rot};
    assign gnt      = NREQ'((pick_dbl << rr_ptr) >> NREQ);

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler: round-robin burst arbitration onto the FIFO write port,
// write pointer ownership, and full / almost-full / level against the synced read pointer.
module fifo_wr_sched
    import fifo_defs::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int DSIZE     = DSIZE_DEF,
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 4,
    parameter int AF_LEVEL  = 12
) (
    input  logic                  wclk_i,
    input  logic                  wrst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*DSIZE-1:0] data_i,
    output logic [NREQ-1:0]       gnt_o,
    input  logic [ADDRSIZE:0]     wq2_rptr_i,
    output logic                  wclken_o,
    output logic [ADDRSIZE-1:0]   waddr_o,
    output logic [DSIZE-1:0]      wdata_o,
    output logic [ADDRSIZE:0]     wptr_o,
    output logic                  wfull_o,
    output logic                  walmost_full_o,
    output logic [ADDRSIZE:0]     wlevel_o
);

    localparam int PW   = $clog2(NREQ);
    localparam int PTRW = ADDRSIZE + 1;

    state_t          state_reg, state_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [PW-1:0]   rr_reg, rr_next;
    logic [3:0]      count_reg, count_next;
    logic [PTRW-1:0] wbin_reg, wbin_next;
    logic [PTRW-1:0] wptr_reg, wgray_next;
    logic [PTRW-1:0] wlevel_reg, level_next;
    logic            wfull_reg, full_next;
    logic            af_reg, af_next;

    logic [PW-1:0]   owner_inc;
    logic [NREQ-1:0] owner_onehot;
    logic [PW-1:0]   arb_rr;
    logic [NREQ-1:0] arb_mask;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic [NREQ-1:0] gnt_sel;
    logic [PTRW-1:0] rq_bin;
    logic            push;

    assign owner_inc    = (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + PW'(1);
    assign owner_onehot = NREQ'(1) << owner_reg;
    // On burst exit the current owner is excluded and the search starts just past it.
    assign arb_rr       = (state_reg == BURST) ? owner_inc : rr_reg;
    assign arb_mask     = (state_reg == BURST) ? owner_onehot : '0;

    fifo_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req    (req_i),
        .rr_ptr (arb_rr),
        .mask   (arb_mask),
        .gnt    (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        count_next = count_reg;
        rr_next    = rr_reg;
        gnt_sel    = '0;
        case (state_reg)
            IDLE: begin
                if (!wfull_reg && (|arb_gnt)) begin
                    gnt_sel    = arb_gnt;
                    owner_next = arb_idx;
                    count_next = 4'd1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (wfull_reg) begin
                    // Burst is parked until space opens; owner and count survive.
                end else if (req_i[owner_reg] && (count_reg < 4'(MAX_BURST))) begin
                    gnt_sel    = owner_onehot;
                    count_next = count_reg + 4'd1;
                end else begin
                    rr_next = owner_inc;
                    if (|arb_gnt) begin
                        gnt_sel    = arb_gnt;
                        owner_next = arb_idx;
                        count_next = 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt_o    = wrst_ni ? gnt_sel : '0;
    assign push     = |gnt_o;
    assign wclken_o = push;
    assign waddr_o  = wbin_reg[ADDRSIZE-1:0];

    always_comb begin
        wdata_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_sel[i]) wdata_o = data_i[i*DSIZE +: DSIZE];
        end
    end

    assign wbin_next  = wbin_reg + PTRW'(push);
    assign wgray_next = PTRW'(bin2gray(16'(wbin_next)));
    assign rq_bin     = PTRW'(gray2bin(16'(wq2_rptr_i)));
    assign level_next = wbin_next - rq_bin;
    assign full_next  = (wgray_next == {~wq2_rptr_i[ADDRSIZE:ADDRSIZE-1], wq2_rptr_i[ADDRSIZE-2:0]});
    assign af_next    = (level_next >= PTRW'(AF_LEVEL));

    always_ff @(posedge wclk_i or negedge wrst_ni) begin
        if (!wrst_ni) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_reg     <= '0;
            count_reg  <= '0;
            wbin_reg   <= '0;
            wptr_reg   <= '0;
            wlevel_reg <= '0;
            wfull_reg  <= 1'b0;
            af_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_reg     <= rr_next;
            count_reg  <= count_next;
            wbin_reg   <= wbin_next;
            wptr_reg   <= wgray_next;
            wlevel_reg <= level_next;
            wfull_reg  <= full_next;
            af_reg     <= af_next;
        end
    end

    assign wptr_o         = wptr_reg;
    assign wfull_o        = wfull_reg;
    assign walmost_full_o = af_reg;
    assign wlevel_o       = wlevel_reg;

endmodule
